lsu_mem_master: RTL and testbench
=================================

Name: lsu_mem_master

Overview:
Load/store initiator that drives the word-addressed, word-wide data memory (async-read, sync-write, WE/WD/A/RD port) on behalf of the core's memory stage. Accepts byte/half/word load and store requests over a valid/ready handshake. Performs sign/zero extension on loads and read-modify-write for sub-word stores. Returns one response per request, with an error flag for misaligned or out-of-range accesses.

Parameters:
DEPTH, 256, number of 32-bit words in the target memory; word index >= DEPTH is out of range
ADDR_W, 32, byte address width of core requests

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
req_valid  input  1  request present
req_ready  output  1  block can accept a request
req_we  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word; 11 is illegal and raises an error
req_unsigned  input  1  loads only: zero-extend when 1, sign-extend when 0
req_addr  input  ADDR_W  byte address
req_wdata  input  32  store data, right-justified
rsp_valid  output  1  response present
rsp_ready  input  1  consumer takes the response
rsp_rdata  output  32  load result; 0 for stores and errors
rsp_err  output  1  misaligned, illegal size, or out-of-range access
mem_we  output  1  memory write enable
mem_a  output  32  word index, {2'b0, addr[31:2]}
mem_wd  output  32  memory write data
mem_rd  input  32  memory combinational read data

Behaviour:
- Reset (rst low, any state): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_we=0, mem_a=0, mem_wd=0.
  - A reset mid-RMW aborts the access with no write.
- States: IDLE, LOAD, RMW_RD, WRITE, RESP.
- IDLE:
  - req_ready=1; all other states drive req_ready=0.
  - On req_valid&&req_ready, latch the request, then branch:
    - error -> RESP with rsp_err=1.
    - load -> LOAD.
    - word store -> WRITE.
    - byte/half store -> RMW_RD.
- Error conditions:
  - half with addr[0]=1.
  - word with addr[1:0]!=0.
  - size 11.
  - addr[31:2] >= DEPTH.
- LOAD:
  - mem_a = latched index.
  - Sample mem_rd and select the lane by addr[1:0]: byte lanes 0..3 at bits [8k+7:8k]; half lanes at [15:0] / [31:16].
  - Extend to 32 bits per req_unsigned; register into rsp_rdata.
  - Next state: RESP.
- RMW_RD:
  - mem_a driven.
  - Merged word = mem_rd with the selected lane replaced by req_wdata[7:0] or [15:0]; register it.
  - Next state: WRITE.
- WRITE:
  - mem_we=1 for exactly one cycle.
  - mem_wd = merged word, or req_wdata for word stores.
  - Next state: RESP.
- RESP:
  - rsp_valid=1, rsp_rdata/rsp_err held stable until rsp_ready.
  - On rsp_valid&&rsp_ready: go to IDLE and clear rsp_valid.
  - A new request is accepted in the cycle after the handshake, not in the same cycle.
- Latency from the accept edge N to rsp_valid high:
  - load N+2.
  - word store N+2.
  - sub-word store N+3.
  - error N+1.
- mem_we is never asserted outside WRITE; errored requests never touch memory.
- mem_a holds the last driven index in IDLE/RESP; mem_we=0 there.

Optional Feature:
Macro LSU_MISALIGN_TRAP_EN.
- Defined: misaligned half/word accesses raise rsp_err as above.
- Undefined: the address is force-aligned instead (half ignores addr[0]; word ignores addr[1:0]) and the access completes normally.
- Illegal size and out-of-range errors apply in both builds.

Decomposition:
- Package lsu_pkg:
  - size encoding constants (SZ_B, SZ_H, SZ_W).
  - state enum typedef.
  - function for the error check.
- Sub-module lsu_data_align (combinational) holds the lane extract/extend and store-merge logic, shared by LOAD and RMW_RD.

Test Plan:
1. SW addr 0x10 data 0x11223344, then LW 0x10 -> mem_we pulses once with mem_a=4 and mem_wd=0x11223344; load returns 0x11223344, rsp_err=0.
2. SB addr 0x11 data 0xAB over word 0x11223344 -> RMW_RD then WRITE, mem_wd=0x1122AB44, rsp_valid at N+3.
3. Word at 0x20 = 0x00008080 -> LB 0x20 returns 0xFFFFFF80; LBU returns 0x00000080; LH returns 0xFFFF8080; LHU returns 0x00008080.
4. SW at 0x2 with macro defined -> rsp_err=1 at N+1, mem_we stays 0. With the macro undefined, the store writes word index 0.
5. LW at 0x400 (index 256, DEPTH=256) -> rsp_err=1, rsp_rdata=0, no mem_we.
6. Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable and req_ready=0. Separately, assert rst low during RMW_RD -> no mem_we pulse and all outputs return to reset values.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory master: access-size codes,
// FSM state encoding and request classification helpers.
// Build option: define LSU_MISALIGN_TRAP_EN to report misaligned half/word
// accesses as errors. Without it, such addresses are force-aligned.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit MISALIGN_TRAP = 1'b1;
`else
  localparam bit MISALIGN_TRAP = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RMW_RD,
    ST_WRITE,
    ST_RESP
  } state_t;

  // A request errors on an illegal size, an out-of-range word index, or
  // (only when trapping is built in) a misaligned half/word address.
  function automatic logic lsu_req_err(input logic [1:0] size,
                                       input logic [1:0] lo,
                                       input logic       oob);
    logic misaligned;
    misaligned = ((size == SZ_H) && lo[0]) ||
                 ((size == SZ_W) && (lo != 2'b00));
    return (size == 2'b11) || oob || (MISALIGN_TRAP && misaligned);
  endfunction

  // Byte offset actually used inside the word: halves drop bit 0 and words
  // drop both bits, which is what force-alignment means.
  function automatic logic [1:0] lsu_eff_off(input logic [1:0] size,
                                             input logic [1:0] lo);
    logic [1:0] off;
    case (size)
      SZ_B:    off = lo;
      SZ_H:    off = {lo[1], 1'b0};
      default: off = 2'b00;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Combinational lane logic shared by loads and sub-word stores: extracts and
// extends the addressed byte/half of a memory word, and builds the merged
// word for a read-modify-write.
module lsu_data_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  lane [4];
  logic [3:0]  lane_sel;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic [7:0] src;

      assign lane[gi] = word[8*gi +: 8];
      assign lane_sel[gi] = ((size == SZ_B) && (off == LANE)) ||
                            ((size == SZ_H) && (off[1] == LANE[1])) ||
                            (size == SZ_W);

      // Store data byte feeding this lane: bytes always come from bits
      // [7:0], halves alternate between the two low store bytes.
      always_comb begin
        src = wdata[8*gi +: 8];
        if (size == SZ_B) begin
          src = wdata[7:0];
        end else if (size == SZ_H) begin
          src = wdata[8*(gi%2) +: 8];
        end
      end

      assign merged[8*gi +: 8] = lane_sel[gi] ? src : lane[gi];
    end
  endgenerate

  // Pick the addressed lane and widen it according to the signedness flag.
  always_comb begin
    lane_b = lane[off];
    lane_h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_B:    load_data = {{24{~is_unsigned & lane_b[7]}}, lane_b};
      SZ_H:    load_data = {{16{~is_unsigned & lane_h[15]}}, lane_h};
      default: load_data = word;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator for the word-wide data memory. One request at a time
// is accepted, executed (plain load, word write, or read-modify-write for
// sub-word stores) and answered with a single response.
// Build option: LSU_MISALIGN_TRAP_EN (see lsu_pkg) selects trap vs.
// force-align for misaligned half/word addresses.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_we,
  output logic [31:0]       mem_a,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd
);

  localparam int IDX_W = ADDR_W - 2;
  localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH);

  state_t      state_reg, state_next;
  logic [1:0]  size_reg, size_next;
  logic        uns_reg, uns_next;
  logic [1:0]  off_reg, off_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [31:0] mem_a_reg, mem_a_next;
  logic [31:0] mem_wd_reg, mem_wd_next;
  logic        mem_we_reg, mem_we_next;
  logic [31:0] rsp_rdata_reg, rsp_rdata_next;
  logic        rsp_err_reg, rsp_err_next;

  logic [IDX_W-1:0] req_idx;
  logic             acc_err;
  logic [31:0]      load_data;
  logic [31:0]      merged;

  assign req_idx = req_addr[ADDR_W-1:2];
  assign acc_err = lsu_req_err(req_size, req_addr[1:0], req_idx >= DEPTH_IDX);

  lsu_data_align u_align (
    .word        (mem_rd),
    .off         (off_reg),
    .size        (size_reg),
    .is_unsigned (uns_reg),
    .wdata       (wdata_reg),
    .load_data   (load_data),
    .merged      (merged)
  );

  // State and datapath registers; reset drops any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      size_reg      <= 2'b00;
      uns_reg       <= 1'b0;
      off_reg       <= 2'b00;
      wdata_reg     <= 32'h0;
      mem_a_reg     <= 32'h0;
      mem_wd_reg    <= 32'h0;
      mem_we_reg    <= 1'b0;
      rsp_rdata_reg <= 32'h0;
      rsp_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      size_reg      <= size_next;
      uns_reg       <= uns_next;
      off_reg       <= off_next;
      wdata_reg     <= wdata_next;
      mem_a_reg     <= mem_a_next;
      mem_wd_reg    <= mem_wd_next;
      mem_we_reg    <= mem_we_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_err_reg   <= rsp_err_next;
    end
  end

  // Next-state and next-register values. mem_we is registered, so it is
  // raised on the edge that enters WRITE and dropped on the edge leaving it.
  always_comb begin
    state_next     = state_reg;
    size_next      = size_reg;
    uns_next       = uns_reg;
    off_next       = off_reg;
    wdata_next     = wdata_reg;
    mem_a_next     = mem_a_reg;
    mem_wd_next    = mem_wd_reg;
    mem_we_next    = 1'b0;
    rsp_rdata_next = rsp_rdata_reg;
    rsp_err_next   = rsp_err_reg;

    case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          size_next      = req_size;
          uns_next       = req_unsigned;
          off_next       = lsu_eff_off(req_size, req_addr[1:0]);
          wdata_next     = req_wdata;
          rsp_rdata_next = 32'h0;
          rsp_err_next   = acc_err;
          if (acc_err) begin
            // Errored requests never drive the memory port.
            state_next = ST_RESP;
          end else begin
            mem_a_next = 32'(req_idx);
            if (!req_we) begin
              state_next = ST_LOAD;
            end else if (req_size == SZ_W) begin
              mem_wd_next = req_wdata;
              mem_we_next = 1'b1;
              state_next  = ST_WRITE;
            end else begin
              state_next = ST_RMW_RD;
            end
          end
        end
      end
      ST_LOAD: begin
        rsp_rdata_next = load_data;
        state_next     = ST_RESP;
      end
      ST_RMW_RD: begin
        mem_wd_next = merged;
        mem_we_next = 1'b1;
        state_next  = ST_WRITE;
      end
      ST_WRITE: begin
        state_next = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign req_ready = (state_reg == ST_IDLE);
  assign rsp_valid = (state_reg == ST_RESP);
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;
  assign mem_we    = mem_we_reg;
  assign mem_a     = mem_a_reg;
  assign mem_wd    = mem_wd_reg;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench for lsu_mem_master: directed scenarios followed by
// random traffic, compared against a byte-arithmetic reference model.
module tb_lsu_mem_master;

  localparam int DEPTH = 256;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;

  int n_chk = 0;
  int n_err = 0;
  int n_txn = 0;

  // Memory seen by the DUT, and the reference copy kept by the model.
  logic [31:0] mem [DEPTH] = '{default: 32'h0};
  logic [31:0] ref_mem [DEPTH] = '{default: 32'h0};
  logic        seed_we = 1'b0;
  logic [7:0]  seed_a = 8'h0;
  logic [31:0] seed_d = 32'h0;
  int          we_count = 0;
  logic [31:0] wr_a = 32'h0;
  logic [31:0] wr_d = 32'h0;

  always #5 clk = ~clk;

  lsu_mem_master #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_we       (mem_we),
    .mem_a        (mem_a),
    .mem_wd       (mem_wd),
    .mem_rd       (mem_rd)
  );

  assign mem_rd = (mem_a < DEPTH) ? mem[mem_a[7:0]] : 32'h0;

  // Synchronous-write memory; also records every write pulse.
  always @(posedge clk) begin
    if (seed_we) begin
      mem[seed_a] <= seed_d;
    end else if (mem_we) begin
      we_count <= we_count + 1;
      wr_a     <= mem_a;
      wr_d     <= mem_wd;
      if (mem_a < DEPTH) mem[mem_a[7:0]] <= mem_wd;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  // Reference behaviour from the access rules, using plain shifts and masks.
  task automatic model(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic err, output logic [31:0] rd,
                       output logic [31:0] wd, output int lat);
    int unsigned idx;
    int          nbytes, sh;
    logic [31:0] ea, w, mask, field;
    idx = addr >> 2;
    err = (size == 2'b11) || (idx >= DEPTH);
    if (TRAP) err = err || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
    ea = addr;
    if (size == 2'b01) ea = addr & ~32'h1;
    if (size == 2'b10) ea = addr & ~32'h3;
    nbytes = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nbytes)) - 32'h1);
    sh = 8 * int'(ea[1:0]);
    rd = 32'h0;
    wd = 32'h0;
    if (err) begin
      lat = 1;
    end else begin
      w = ref_mem[idx];
      if (!we) begin
        field = (w >> sh) & mask;
        if (!uns && nbytes < 4 && field[8*nbytes-1]) field = field | ~mask;
        rd  = field;
        lat = 2;
      end else begin
        wd  = (w & ~(mask << sh)) | ((wdata & mask) << sh);
        lat = (nbytes == 4) ? 2 : 3;
      end
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int hold, output logic [31:0] rd_obs);
    logic        e_err;
    logic [31:0] e_rd, e_wd;
    int          e_lat, lat, wc0;
    model(we, size, uns, addr, wdata, e_err, e_rd, e_wd, e_lat);
    @(negedge clk);
    check_eq("req_ready_idle", {31'b0, req_ready}, 32'd1);
    wc0          = we_count;
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    rd_obs = rsp_rdata;
    check_eq("latency", 32'(lat), 32'(e_lat));
    check_eq("rsp_rdata", rsp_rdata, e_rd);
    check_eq("rsp_err", {31'b0, rsp_err}, {31'b0, e_err});
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check_eq("hold_valid", {31'b0, rsp_valid}, 32'd1);
      check_eq("hold_rdata", rsp_rdata, e_rd);
      check_eq("hold_ready", {31'b0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check_eq("post_valid", {31'b0, rsp_valid}, 32'd0);
    check_eq("write_count", 32'(we_count - wc0), (we && !e_err) ? 32'd1 : 32'd0);
    if (we && !e_err) begin
      check_eq("write_a", wr_a, addr >> 2);
      check_eq("write_d", wr_d, e_wd);
      ref_mem[addr >> 2] = e_wd;
    end
    n_txn++;
    $display("txn %0d we=%0d size=%0d uns=%0d addr=%08h wdata=%08h rdata=%08h err=%0d lat=%0d",
             n_txn, we, size, uns, addr, wdata, rsp_rdata_obs(rd_obs), e_err, lat);
  endtask

  function automatic logic [31:0] rsp_rdata_obs(input logic [31:0] v);
    return v;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
    check_eq({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
    check_eq({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
    check_eq({tag, "_rsp_err"}, {31'b0, rsp_err}, 32'd0);
    check_eq({tag, "_mem_we"}, {31'b0, mem_we}, 32'd0);
    check_eq({tag, "_mem_a"}, mem_a, 32'h0);
    check_eq({tag, "_mem_wd"}, mem_wd, 32'h0);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] v;
    int          wc0;
    logic [1:0]  sz;
    logic [31:0] a;
    int          r;

    rst          = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    rsp_ready    = 1'b0;

    // Seed both memories identically while reset is held.
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      v          = $urandom;
      seed_we    = 1'b1;
      seed_a     = 8'(i);
      seed_d     = v;
      ref_mem[i] = v;
    end
    @(negedge clk);
    seed_we = 1'b0;
    check_reset_outputs("reset");
    rst = 1'b1;

    // Word store then load back.
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344, 0, rd);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, rd);
    check_eq("lw_0x10", rd, 32'h1122_3344);

    // Byte store merged into the word.
    do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00AB, 0, rd);
    check_eq("sb_merge", ref_mem[4], 32'h1122_AB44);

    // Sign/zero extension of byte and half loads.
    do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h0000_8080, 0, rd);
    do_req(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 0, rd);
    check_eq("lb", rd, 32'hFFFF_FF80);
    do_req(1'b0, 2'b00, 1'b1, 32'h20, 32'h0, 0, rd);
    check_eq("lbu", rd, 32'h0000_0080);
    do_req(1'b0, 2'b01, 1'b0, 32'h20, 32'h0, 0, rd);
    check_eq("lh", rd, 32'hFFFF_8080);
    do_req(1'b0, 2'b01, 1'b1, 32'h20, 32'h0, 0, rd);
    check_eq("lhu", rd, 32'h0000_8080);

    // Misaligned word store: trapped or force-aligned onto word 0.
    do_req(1'b1, 2'b10, 1'b0, 32'h2, 32'hCAFE_F00D, 0, rd);
    // Out-of-range load and illegal size.
    do_req(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 0, rd);
    do_req(1'b0, 2'b11, 1'b0, 32'h8, 32'h0, 0, rd);

    // Response held for five cycles with the consumer stalled.
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5, rd);

    // Reset asserted while the read half of a read-modify-write is active.
    @(negedge clk);
    wc0          = we_count;
    req_valid    = 1'b1;
    req_we       = 1'b1;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'h31;
    req_wdata    = 32'h55;
    @(posedge clk);
    #1 req_valid = 1'b0;
    check_eq("rmw_busy_ready", {31'b0, req_ready}, 32'd0);
    #2 rst = 1'b0;
    #1 check_reset_outputs("midrst");
    @(negedge clk);
    @(negedge clk);
    check_eq("midrst_no_write", 32'(we_count - wc0), 32'd0);
    rst = 1'b1;
    do_req(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 0, rd);

    // Random traffic over a small window plus occasional out-of-range.
    for (int t = 0; t < 200; t++) begin
      r  = int'($urandom_range(0, 15));
      sz = (r == 15) ? 2'b11 : 2'(r % 3);
      if ($urandom_range(0, 9) == 0) a = 32'h400 + 32'($urandom_range(0, 255));
      else a = 32'($urandom_range(0, 127));
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
             int'($urandom_range(0, 2)), rd);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
